// File: rtl/reg_bank_write_pkg.sv
// rtl/reg_bank_write_pkg.sv - shared constants and types for the ARM register bank write side
package reg_bank_write_pkg;
  localparam int          NUM_REGS     = 16;
  localparam logic [3:0]  REG_PC       = 4'd15;
  localparam logic [3:0]  REG_LR       = 4'd14;
  localparam logic [3:0]  REG_SP       = 4'd13;
  localparam int          DEF_PC_STEP  = 4;
  localparam logic [31:0] DEF_PC_RESET = 32'h0000_0000;

  typedef logic [NUM_REGS-1:0] reg_sel_t;
endpackage

// File: rtl/reg_bank_write_dec_4to16.sv
// rtl/reg_bank_write_dec_4to16.sv - 4-to-16 one-hot decoder with enable
module dec_4to16
  import reg_bank_write_pkg::*;
(
  input  logic     en_i,
  input  logic [3:0] addr_i,
  output reg_sel_t onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/reg_bank_write.sv
// rtl/reg_bank_write.sv - 16x DW register bank write side with R15 auto-increment
// Optional second write port under REG_BANK_DUAL_WRITE_EN.
module reg_bank_write
  import reg_bank_write_pkg::*;
#(
  parameter int          DW       = 32,
  parameter int          PC_STEP  = DEF_PC_STEP,
  parameter logic [DW-1:0] PC_RESET = DW'(DEF_PC_RESET)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we_a,
  input  logic [3:0]             wa_a,
  input  logic [DW-1:0]          wd_a,
`ifdef REG_BANK_DUAL_WRITE_EN
  input  logic                   we_b,
  input  logic [3:0]             wa_b,
  input  logic [DW-1:0]          wd_b,
`endif
  input  logic                   pc_inc,
  output logic [NUM_REGS*DW-1:0] q_flat,
  output logic [NUM_REGS-1:0]    wr_onehot,
  output logic [DW-1:0]          pc
);

  reg_sel_t      en_a;
  reg_sel_t      en_all;
  logic [DW-1:0] regs_q [NUM_REGS];
  logic [DW-1:0] regs_d [NUM_REGS];
  reg_sel_t      wr_onehot_q;

  dec_4to16 u_dec_a (
    .en_i     (we_a),
    .addr_i   (wa_a),
    .onehot_o (en_a)
  );

`ifdef REG_BANK_DUAL_WRITE_EN
  reg_sel_t en_b;
  reg_sel_t en_b_eff;

  dec_4to16 u_dec_b (
    .en_i     (we_b),
    .addr_i   (wa_b),
    .onehot_o (en_b)
  );

  // Port A wins an address collision; masking with en_a drops only that bit.
  assign en_b_eff = en_b & ~en_a;
  assign en_all   = en_a | en_b;
`else
  assign en_all   = en_a;
`endif

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (en_a[i]) regs_d[i] = wd_a;
`ifdef REG_BANK_DUAL_WRITE_EN
      else if (en_b_eff[i]) regs_d[i] = wd_b;
`endif
    end
    // An explicit R15 write from either port is a branch and suppresses the increment.
    if (!en_all[REG_PC] && pc_inc)
      regs_d[REG_PC] = regs_q[REG_PC] + DW'(PC_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= (i == int'(REG_PC)) ? PC_RESET : '0;
      wr_onehot_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= regs_d[i];
      wr_onehot_q <= en_all;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign q_flat[g*DW +: DW] = regs_q[g];
  end

  assign wr_onehot = wr_onehot_q;
  assign pc        = regs_q[REG_PC];

endmodule
